// File: rtl/tx_pcs_pkg.sv
// Shared TX PCS constants: 64b/66b sync headers, IDLE/ERROR block images and
// the gearbox sequence width.
package tx_pcs_pkg;

    localparam int unsigned SEQ_W = 6;

    localparam logic [1:0]  HDR_DATA = 2'b10;
    localparam logic [1:0]  HDR_CTRL = 2'b01;
    localparam logic [7:0]  BT_IDLE  = 8'h1E;

    localparam logic [65:0] IDLE_BLK = {56'h0, BT_IDLE, HDR_CTRL};
    localparam logic [65:0] ERR_BLK  = {56'h3C78F1E3C78F1E, BT_IDLE, HDR_CTRL};

    function automatic logic hdr_legal(input logic [1:0] hdr);
        return (hdr == HDR_DATA) || (hdr == HDR_CTRL);
    endfunction

endpackage

// File: rtl/tx_gearbox_sched_if.sv
// Encoder-to-scrambler bus of tx_gearbox_sched: upstream block handshake,
// issued block to the scrambler, sequence and event pulses.
interface tx_gearbox_sched_if;
    import tx_pcs_pkg::*;

    logic [65:0]      up_data_i;
    logic             up_valid_i;
    logic             up_ready_o;
    logic [65:0]      blk_o;
    logic             blk_vld_o;
    logic [SEQ_W-1:0] txseq_o;
    logic             hdr_err_o;
    logic             idle_ins_o;

    modport master (
        output up_data_i, up_valid_i,
        input  up_ready_o, blk_o, blk_vld_o, txseq_o, hdr_err_o, idle_ins_o
    );

    modport slave (
        input  up_data_i, up_valid_i,
        output up_ready_o, blk_o, blk_vld_o, txseq_o, hdr_err_o, idle_ins_o
    );

endinterface

// File: rtl/tx_seq_cnt.sv
// Free-running gearbox sequence counter (0..SEQ_MAX, wraps) with pause-slot
// decode; shared with the RX gearbox slip logic.
module tx_seq_cnt
    import tx_pcs_pkg::*;
#(
    parameter int unsigned SEQ_MAX   = 32,
    parameter int unsigned PAUSE_SEQ = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    output logic [SEQ_W-1:0] slot_o,
    output logic             pause_o
);

    logic [SEQ_W-1:0] slot_r;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            slot_r <= '0;
        end else if (slot_r == SEQ_W'(SEQ_MAX)) begin
            slot_r <= '0;
        end else begin
            slot_r <= slot_r + 1'b1;
        end
    end

    assign slot_o  = slot_r;
    assign pause_o = (slot_r == SEQ_W'(PAUSE_SEQ));

endmodule

// File: rtl/tx_gearbox_sched.sv
// TX slot scheduler between 64b/66b encoder and scrambler: grants one block per
// non-pause slot, inserts IDLE/ERROR blocks. Optional stats: TX_SCHED_STATS_EN.
module tx_gearbox_sched
    import tx_pcs_pkg::*;
#(
    parameter int unsigned SEQ_MAX   = 32,
    parameter int unsigned PAUSE_SEQ = 32,
    parameter int unsigned START_DLY = 16
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        en_i,
`ifdef TX_SCHED_STATS_EN
    input  logic        stats_clr_i,
    output logic [31:0] idle_cnt_o,
    output logic [15:0] hdr_err_cnt_o,
`endif
    tx_gearbox_sched_if.slave up
);

    localparam int unsigned DLY_W = (START_DLY < 2) ? 1 : $clog2(START_DLY + 1);

    logic [DLY_W-1:0] dly_r;
    logic [SEQ_W-1:0] slot;
    logic             pause;
    logic             go;
    logic             grant;
    logic             hdr_ok;

    logic [65:0]      blk_r;
    logic             vld_r;
    logic [SEQ_W-1:0] txseq_r;
    logic             hdr_err_r;
    logic             idle_ins_r;

    tx_seq_cnt #(
        .SEQ_MAX   (SEQ_MAX),
        .PAUSE_SEQ (PAUSE_SEQ)
    ) u_seq_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .slot_o  (slot),
        .pause_o (pause)
    );

    // Start-up hold-off; the sequence counter keeps running underneath it.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            dly_r <= DLY_W'(START_DLY);
        end else if (dly_r != '0) begin
            dly_r <= dly_r - 1'b1;
        end
    end

    always_comb begin
        go     = (dly_r == '0) && en_i;
        grant  = go && !pause;
        hdr_ok = hdr_legal(up.up_data_i[1:0]);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            blk_r      <= '0;
            vld_r      <= 1'b0;
            txseq_r    <= '0;
            hdr_err_r  <= 1'b0;
            idle_ins_r <= 1'b0;
        end else begin
            txseq_r    <= slot;
            vld_r      <= grant;
            hdr_err_r  <= grant && up.up_valid_i && !hdr_ok;
            idle_ins_r <= grant && !up.up_valid_i;
            if (grant) begin
                if (!up.up_valid_i) begin
                    blk_r <= IDLE_BLK;
                end else if (hdr_ok) begin
                    blk_r <= up.up_data_i;
                end else begin
                    blk_r <= ERR_BLK;
                end
            end
        end
    end

    assign up.up_ready_o = grant;
    assign up.blk_o      = blk_r;
    assign up.blk_vld_o  = vld_r;
    assign up.txseq_o    = txseq_r;
    assign up.hdr_err_o  = hdr_err_r;
    assign up.idle_ins_o = idle_ins_r;

`ifdef TX_SCHED_STATS_EN
    logic [31:0] idle_cnt_r;
    logic [15:0] hdr_err_cnt_r;

    // Counts the registered pulses; clear takes priority over a same-cycle event.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            idle_cnt_r    <= '0;
            hdr_err_cnt_r <= '0;
        end else if (stats_clr_i) begin
            idle_cnt_r    <= '0;
            hdr_err_cnt_r <= '0;
        end else begin
            if (idle_ins_r && (idle_cnt_r != '1)) begin
                idle_cnt_r <= idle_cnt_r + 1'b1;
            end
            if (hdr_err_r && (hdr_err_cnt_r != '1)) begin
                hdr_err_cnt_r <= hdr_err_cnt_r + 1'b1;
            end
        end
    end

    assign idle_cnt_o    = idle_cnt_r;
    assign hdr_err_cnt_o = hdr_err_cnt_r;
`endif

endmodule

// File: doc/tx_gearbox_sched.md
Name: tx_gearbox_sched

Overview:
Transmit-side slot scheduler between the 64b/66b encoder and the TX scrambler, which feeds the GT 64b/66b external-sequence gearbox. It keeps the free-running gearbox sequence counter and grants the upstream encoder one 66-bit block per slot. It inserts an IDLE block when the encoder has no data and replaces blocks with illegal sync headers by an ERROR block. It drives the scrambler's `data_i`/`data_vld_i`, so that `data_vld_i` is low exactly in the gearbox pause slot.

Parameters:
- `SEQ_MAX`, default 32: last sequence value; the counter runs 0..`SEQ_MAX` and wraps to 0.
- `PAUSE_SEQ`, default 32: sequence value in which no block is issued (gearbox pause). Legal range is 0..`SEQ_MAX`.
- `START_DLY`, default 16: number of cycles after reset release during which no blocks are issued; the counter runs during this period.

Ports:
- `clk_i`  in  1  TX user clock.
- `rst_n_i`  in  1  asynchronous active-low reset.
- `en_i`  in  1  link TX enable. When low, no grants are given and no blocks are issued.
- `up_data_i`  in  66  encoder block: [65:2] payload, [1:0] sync header.
- `up_valid_i`  in  1  encoder block available.
- `up_ready_o`  out  1  grant. A transfer happens when `up_valid_i` and `up_ready_o` are both high.
- `blk_o`  out  66  block to scrambler `data_i`.
- `blk_vld_o`  out  1  to scrambler `data_vld_i`.
- `txseq_o`  out  6  gearbox sequence aligned with `blk_o`.
- `hdr_err_o`  out  1  one-cycle pulse when an illegal-header block is replaced.
- `idle_ins_o`  out  1  one-cycle pulse when an IDLE block is inserted.

Behaviour:
- Reset is asynchronous and active-low. Reset values of all outputs:
  - `blk_o` = 0
  - `blk_vld_o` = 0
  - `txseq_o` = 0
  - `up_ready_o` = 0
  - `hdr_err_o` = 0
  - `idle_ins_o` = 0
- Internal reset state: `slot_r` = 0, `dly_r` = `START_DLY`.
- `slot_r` increments every cycle regardless of `en_i`. It wraps from `SEQ_MAX` to 0.
- `dly_r` decrements to 0 and then holds. `go` = (`dly_r` == 0) && `en_i`.
- `up_ready_o` is combinational: `go` && (`slot_r` != `PAUSE_SEQ`). It does not depend on `up_valid_i`.
- Registered on each clock edge:
  - `txseq_o` <= `slot_r`.
  - `blk_vld_o` <= `up_ready_o`.
- When `up_ready_o` is high, the block registered into `blk_o` is selected as follows:
  - `up_valid_i` high with header `HDR_DATA` or `HDR_CTRL`: `blk_o` <= `up_data_i`.
  - `up_valid_i` high with header 2'b00 or 2'b11: `blk_o` <= `ERR_BLK`; `hdr_err_o` pulses. The block is consumed.
  - `up_valid_i` low: `blk_o` <= `IDLE_BLK`; `idle_ins_o` pulses.
- When `up_ready_o` is low, `blk_o` holds its value and both pulses are 0.
- Latency from accepted block to `blk_o`/`blk_vld_o` is 1 cycle. The scrambler adds one more cycle.
- Pause slot:
  - `blk_vld_o` is low in the cycle where `txseq_o` == `PAUSE_SEQ`.
  - Exactly one non-issued slot occurs per `SEQ_MAX`+1 cycles while `go` is high.
- `en_i` deasserted mid-stream:
  - Grants stop in the same cycle; no block is lost or duplicated.
  - The sequence counter keeps counting.
  - On reassertion, issuing resumes at the current slot.
- Reset asserted mid-operation: all state returns to its reset value immediately, and the `START_DLY` hold-off restarts.

Optional Feature:
- Macro `TX_SCHED_STATS_EN`.
- When defined:
  - Adds outputs `idle_cnt_o` [31:0] and `hdr_err_cnt_o` [15:0].
  - Both are saturating counters of `idle_ins_o` and `hdr_err_o` pulses.
  - Both are cleared by reset and by input `stats_clr_i` (1-bit, synchronous). If clear and an event occur in the same cycle, the clear wins.
- When undefined: these ports and counters are absent. Behaviour is otherwise identical.

Decomposition:
- Package `tx_pcs_pkg` holds:
  - `HDR_DATA` = 2'b10 and `HDR_CTRL` = 2'b01.
  - `BT_IDLE` = 8'h1E.
  - `IDLE_BLK` = {56'h0, 8'h1E, 2'b01}.
  - `ERR_BLK` = {56'h3C78F1E3C78F1E, 8'h1E, 2'b01}.
  - `SEQ_W` = 6.
- Sub-module `tx_seq_cnt` (parameters `SEQ_MAX`, `PAUSE_SEQ`) contains `slot_r` and the pause decode, and is reused by the RX gearbox slip logic.

Test Plan:
- Reset, `en_i`=1, `up_valid_i`=0 for 80 cycles -> `blk_vld_o`=0 for the first 16 cycles. After that, `blk_o`=`IDLE_BLK` with `idle_ins_o`=1 on every issued slot, and `blk_vld_o`=0 whenever `txseq_o`==32.
- Continuous valid data with a payload counter and header 2'b10 -> `up_ready_o` is low exactly 1 cycle in 33. The output sequence is gap-free in order with no duplicates, and each block appears 1 cycle after acceptance.
- Inject header 2'b11 at payload 64'h55 -> the next `blk_o`=`ERR_BLK` and `hdr_err_o`=1 for one cycle. The following data continues unchanged.
- Drop `en_i` for 10 cycles during valid traffic -> `up_ready_o`=0 and `blk_vld_o`=0 for those cycles, and `txseq_o` keeps wrapping 32->0. After reassertion, the stream resumes with no loss.
- Assert `rst_n_i` low asynchronously mid-block -> all outputs are 0 immediately, and the 16-cycle hold-off repeats after release.
- With `TX_SCHED_STATS_EN`: 5 header errors then `stats_clr_i` -> `hdr_err_cnt_o`=5, then 0 in the cycle after the clear. A clear coincident with an event leaves 0.
